// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator dispatch block.
// Contents: FLOOR_W, EMPTY_FLOOR, the dispatcher state enum and the
// timer_width() helper that sizes the shared travel/door down-counter.
package elevator_pkg;

  localparam int unsigned FLOOR_W = 4;
  localparam logic [FLOOR_W-1:0] EMPTY_FLOOR = 4'd0;

  typedef enum logic [2:0] {
    StIdle,
    StMove,
    StDoor,
    StPop,
    StSettle
  } state_e;

  // The counter only ever holds reload values (ticks - 1), so clog2 of the larger tick count is
  // enough. The result is clamped to 1 so that a 1-tick configuration still gets a real register.
  function automatic int unsigned timer_width(input int unsigned floor_ticks,
                                              input int unsigned door_ticks);
    int unsigned m;
    int unsigned w;
    m = (floor_ticks > door_ticks) ? floor_ticks : door_ticks;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/elevator_tick_timer.sv
// Loadable down-counter shared by the travel and door phases of the dispatcher.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset (count clears to 0)
//   load        - load load_value on this edge (wins over dec)
//   load_value  - value to load
//   dec         - decrement by one; holds at zero instead of wrapping
//   zero        - count is zero
module elevator_tick_timer #(
  parameter int unsigned Width = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [Width-1:0] count_q;
  logic [Width-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/elevator_dispatch.sv
// Elevator dispatcher: consumes the head of the floor request queue, moves the cabin floor by
// floor, holds the door open, then pops the served request.
// Ports:
//   clk, rst_n     - clock and asynchronous active-low reset
//   enable         - permits departure from idle
//   head_floor     - queue head (0 = queue empty); sampled only while idle
//   door_hold      - keep door open (only when DOOR_HOLD_EN is defined)
//   queue_addr     - constant 0, queue read address
//   shift          - one-cycle pulse popping the queue head
//   current_floor  - cabin floor 1..15
//   target_floor   - latched destination, 0 while idle
//   moving_up/down - direction flags, mutually exclusive
//   door_open      - door open
//   busy           - dispatcher not idle
// Build option: define DOOR_HOLD_EN to add the door_hold input.
module elevator_dispatch
  import elevator_pkg::*;
#(
  parameter int unsigned FLOOR_TICKS = 4,
  parameter int unsigned DOOR_TICKS  = 8,
  parameter int unsigned INIT_FLOOR  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [FLOOR_W-1:0] head_floor,
`ifdef DOOR_HOLD_EN
  input  logic               door_hold,
`endif
  output logic [FLOOR_W-1:0] queue_addr,
  output logic               shift,
  output logic [FLOOR_W-1:0] current_floor,
  output logic [FLOOR_W-1:0] target_floor,
  output logic               moving_up,
  output logic               moving_down,
  output logic               door_open,
  output logic               busy
);

  localparam int unsigned TimerW = timer_width(FLOOR_TICKS, DOOR_TICKS);
  localparam logic [TimerW-1:0] FloorReload = TimerW'(FLOOR_TICKS - 1);
  localparam logic [TimerW-1:0] DoorReload  = TimerW'(DOOR_TICKS - 1);

  state_e state_q;

  logic              timer_load;
  logic [TimerW-1:0] timer_value;
  logic              timer_dec;
  logic              timer_zero;
  logic              hold_active;
  logic              start_trip;
  logic [FLOOR_W-1:0] step_floor;

`ifdef DOOR_HOLD_EN
  assign hold_active = door_hold;
`else
  assign hold_active = 1'b0;
`endif

  assign queue_addr = '0;
  assign start_trip = enable && (head_floor != EMPTY_FLOOR);
  // Floor the cabin reaches when the current travel tick expires.
  assign step_floor = moving_up ? (current_floor + 1'b1) : (current_floor - 1'b1);

  // Timer control is a function of the registered state, so the counter update lines up with
  // the state transition taken on the same edge.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = FloorReload;
    timer_dec   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_trip) begin
          timer_load  = 1'b1;
          timer_value = (head_floor == current_floor) ? DoorReload : FloorReload;
        end
      end
      StMove: begin
        if (timer_zero) begin
          timer_load  = 1'b1;
          timer_value = (step_floor == target_floor) ? DoorReload : FloorReload;
        end else begin
          timer_dec = 1'b1;
        end
      end
      StDoor: begin
        if (hold_active) begin
          timer_load  = 1'b1;
          timer_value = DoorReload;
        end else begin
          timer_dec = 1'b1;
        end
      end
      default: ;
    endcase
  end

  elevator_tick_timer #(
    .Width(TimerW)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (timer_load),
    .load_value(timer_value),
    .dec       (timer_dec),
    .zero      (timer_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      current_floor <= FLOOR_W'(INIT_FLOOR);
      target_floor  <= EMPTY_FLOOR;
      moving_up     <= 1'b0;
      moving_down   <= 1'b0;
      door_open     <= 1'b0;
      shift         <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_trip) begin
            target_floor <= head_floor;
            busy         <= 1'b1;
            if (head_floor == current_floor) begin
              door_open <= 1'b1;
              state_q   <= StDoor;
            end else begin
              moving_up   <= (head_floor > current_floor);
              moving_down <= (head_floor < current_floor);
              state_q     <= StMove;
            end
          end
        end
        StMove: begin
          if (timer_zero) begin
            current_floor <= step_floor;
            if (step_floor == target_floor) begin
              moving_up   <= 1'b0;
              moving_down <= 1'b0;
              door_open   <= 1'b1;
              state_q     <= StDoor;
            end
          end
        end
        StDoor: begin
          // A held door must not close even if the counter happens to sit at zero.
          if (timer_zero && !hold_active) begin
            door_open <= 1'b0;
            shift     <= 1'b1;
            state_q   <= StPop;
          end
        end
        StPop: begin
          shift        <= 1'b0;
          target_floor <= EMPTY_FLOOR;
          state_q      <= StSettle;
        end
        StSettle: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_dispatch.sv
module tb_elevator_dispatch;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [3:0] head_floor;
  logic       door_hold;
  logic [3:0] queue_addr;
  logic       shift;
  logic [3:0] current_floor;
  logic [3:0] target_floor;
  logic       moving_up;
  logic       moving_down;
  logic       door_open;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int shift_cnt = 0;

  elevator_dispatch #(
    .FLOOR_TICKS(4),
    .DOOR_TICKS (8),
    .INIT_FLOOR (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .head_floor   (head_floor),
`ifdef DOOR_HOLD_EN
    .door_hold    (door_hold),
`endif
    .queue_addr   (queue_addr),
    .shift        (shift),
    .current_floor(current_floor),
    .target_floor (target_floor),
    .moving_up    (moving_up),
    .moving_down  (moving_down),
    .door_open    (door_open),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift is a one-cycle pulse; counting it at the falling edge counts each pulse once.
  always @(negedge clk) if (shift) shift_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input int flr, input int tgt, input int up,
                              input int dn, input int door, input int bsy);
    check({tag, " floor"}, int'(current_floor), flr);
    check({tag, " target"}, int'(target_floor), tgt);
    check({tag, " up"}, int'(moving_up), up);
    check({tag, " down"}, int'(moving_down), dn);
    check({tag, " door"}, int'(door_open), door);
    check({tag, " busy"}, int'(busy), bsy);
  endtask

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b0;
    head_floor = 4'd0;
    door_hold  = 1'b0;
    repeat (2) tick();
    check_status("reset", 1, 0, 0, 0, 0, 0);
    check("reset shift", int'(shift), 0);
    check("queue_addr", int'(queue_addr), 0);
    rst_n = 1'b1;
    tick();

    // Up trip 1 -> 5.
    head_floor = 4'd5;
    enable     = 1'b1;
    tick();
    enable = 1'b0;
    check_status("up start", 1, 5, 1, 0, 0, 1);
    repeat (3) tick();
    check("up before first step", int'(current_floor), 1);
    tick();
    check("up step 2", int'(current_floor), 2);
    for (int k = 3; k <= 5; k++) begin
      repeat (4) tick();
      check($sformatf("up step %0d", k), int'(current_floor), k);
    end
    check_status("up arrive", 5, 5, 0, 0, 1, 1);
    repeat (7) tick();
    check("up door last", int'(door_open), 1);
    check("up no early shift", shift_cnt, 0);
    tick();
    check("up door closed", int'(door_open), 0);
    check("up shift pulse", int'(shift), 1);
    tick();
    check("up shift drop", int'(shift), 0);
    check("up settle target", int'(target_floor), 0);
    check("up settle busy", int'(busy), 1);
    tick();
    check_status("up idle", 5, 0, 0, 0, 0, 0);
    check("up shift count", shift_cnt, 1);

    // Same-floor request at 5.
    head_floor = 4'd5;
    enable     = 1'b1;
    tick();
    enable = 1'b0;
    check_status("same start", 5, 5, 0, 0, 1, 1);
    repeat (7) tick();
    check("same door last", int'(door_open), 1);
    tick();
    check("same shift", int'(shift), 1);
    check("same door closed", int'(door_open), 0);
    repeat (2) tick();
    check("same idle", int'(busy), 0);
    check("same shift count", shift_cnt, 2);

    // Down trip 5 -> 2, head change during travel ignored.
    head_floor = 4'd2;
    enable     = 1'b1;
    tick();
    enable     = 1'b0;
    head_floor = 4'd9;
    check_status("down start", 5, 2, 0, 1, 0, 1);
    repeat (11) tick();
    check("down before stop", int'(current_floor), 3);
    check("down target held", int'(target_floor), 2);
    tick();
    check_status("down arrive", 2, 2, 0, 0, 1, 1);
    repeat (10) tick();
    check_status("down idle", 2, 0, 0, 0, 0, 0);
    check("down shift count", shift_cnt, 3);

    // Empty queue, then disabled with a pending request.
    head_floor = 4'd0;
    enable     = 1'b1;
    repeat (50) tick();
    check("empty busy", int'(busy), 0);
    check("empty floor", int'(current_floor), 2);
    enable     = 1'b0;
    head_floor = 4'd7;
    repeat (50) tick();
    check("disabled busy", int'(busy), 0);
    check("disabled target", int'(target_floor), 0);
    check("idle shift count", shift_cnt, 3);

    // Reset mid-trip 2 -> 4 while at floor 3.
    head_floor = 4'd4;
    enable     = 1'b1;
    tick();
    enable = 1'b0;
    repeat (5) tick();
    check("pre-reset floor", int'(current_floor), 3);
    check("pre-reset up", int'(moving_up), 1);
    rst_n = 1'b0;
    #1;
    check_status("async reset", 1, 0, 0, 0, 0, 0);
    check("async reset shift", int'(shift), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("post-reset busy", int'(busy), 0);
    check("post-reset shift count", shift_cnt, 3);

`ifdef DOOR_HOLD_EN
    // Door hold at floor 1: hold sampled on door edges 3..7, door closes 8 edges after release.
    head_floor = 4'd1;
    enable     = 1'b1;
    tick();
    enable = 1'b0;
    check("hold door open", int'(door_open), 1);
    repeat (2) tick();
    door_hold = 1'b1;
    repeat (5) tick();
    door_hold = 1'b0;
    check("hold during", int'(door_open), 1);
    repeat (7) tick();
    check("hold last open", int'(door_open), 1);
    check("hold no shift yet", shift_cnt, 3);
    tick();
    check("hold closed", int'(door_open), 0);
    check("hold shift", int'(shift), 1);
    repeat (2) tick();
    check("hold idle", int'(busy), 0);
    check("hold shift count", shift_cnt, 4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
